sjr_method_checker: RTL and testbench

Synthesizable self-checking driver for a single Synthesijer-generated method port, using the `*_req` / `*_busy` / `*_return` handshake.
- On `start`, it:
  - pulses a reset into the device under test (DUT);
  - waits a settle period;
  - issues `NUM_CALLS` method calls, driving call index `k` on `dut_idx`;
  - compares each return against a preloaded expected table;
  - reports pass/fail, an error count and timeouts.
- It sits beside the DUT in FPGA bring-up builds and in regression benches, so a simulation bench only monitors `done` and `pass`.

---
 rtl/sjr_method_checker.sv | 153 +++++++++++++++
 tb/tb_sjr_method_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sjr_method_checker.sv
// rtl/sjr_method_checker.sv - self-checking driver for one req/busy/return method port
// Resets the DUT, issues NUM_CALLS calls and compares each return against a loadable table.
module sjr_method_checker #(
    parameter int RET_WIDTH        = 1,
    parameter int IDX_WIDTH        = 32,
    parameter int NUM_CALLS        = 4,
    parameter int DUT_RESET_CYCLES = 6,
    parameter int SETTLE_CYCLES    = 92,
    parameter int GUARD_CYCLES     = 4,
    parameter int TIMEOUT          = 10000,
    localparam int AW = (NUM_CALLS > 1) ? $clog2(NUM_CALLS) : 1,
    localparam int CW = $clog2(NUM_CALLS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 exp_we,
    input  logic [AW-1:0]        exp_addr,
    input  logic [RET_WIDTH-1:0] exp_data,
    output logic                 dut_reset,
    output logic                 dut_req,
    output logic [IDX_WIDTH-1:0] dut_idx,
    input  logic                 dut_busy,
    input  logic [RET_WIDTH-1:0] dut_return,
    output logic                 running,
    output logic                 done,
    output logic                 pass,
    output logic [CW-1:0]        err_count,
    output logic [AW-1:0]        first_fail,
    output logic                 timed_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_DRST, S_SETTLE, S_ISSUE, S_GUARD, S_WAIT, S_CHECK, S_DONE
    } state_t;

    state_t                 state, state_n;
    logic [31:0]            cnt;
    logic [AW-1:0]          k, k_n;
    logic [CW-1:0]          err_n;
    logic [AW-1:0]          ff_n;
    logic                   tmo_n;
    logic [RET_WIDTH-1:0]   ret_q;
    logic                   to_q;
    logic                   fail;
    logic                   last;
    logic [RET_WIDTH-1:0]   exp_mem [NUM_CALLS];

    // Table survives reset so it can be loaded once and reused across runs.
    always_ff @(posedge clk) begin
        if (exp_we && (32'(exp_addr) < 32'(NUM_CALLS)))
            exp_mem[exp_addr] <= exp_data;
    end

    assign fail = to_q || (ret_q != exp_mem[k]);
    assign last = (k == AW'(NUM_CALLS - 1));

    always_comb begin
        state_n = state;
        k_n     = k;
        err_n   = err_count;
        ff_n    = first_fail;
        tmo_n   = timed_out;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_DRST;
                    k_n     = '0;
                    err_n   = '0;
                    ff_n    = '0;
                    tmo_n   = 1'b0;
                end
            end
            S_DRST: begin
                if (cnt == 32'(DUT_RESET_CYCLES - 1))
                    state_n = (SETTLE_CYCLES == 0) ? S_ISSUE : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == 32'(SETTLE_CYCLES - 1))
                    state_n = S_ISSUE;
            end
            S_ISSUE: begin
                state_n = (GUARD_CYCLES > 1) ? S_GUARD : S_WAIT;
            end
            S_GUARD: begin
                if (cnt == 32'(GUARD_CYCLES - 1))
                    state_n = S_WAIT;
            end
            S_WAIT: begin
                if (!dut_busy || (cnt >= 32'(TIMEOUT)))
                    state_n = S_CHECK;
            end
            S_CHECK: begin
                if (fail) begin
                    if (err_count != '1)
                        err_n = err_count + CW'(1);
                    if (err_count == '0)
                        ff_n = k;
                    if (to_q)
                        tmo_n = 1'b1;
                end
                if (last) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_ISSUE;
                    k_n     = k + AW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            k          <= '0;
            ret_q      <= '0;
            to_q       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            timed_out  <= 1'b0;
            dut_reset  <= 1'b0;
            dut_req    <= 1'b0;
            dut_idx    <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            err_count  <= err_n;
            first_fail <= ff_n;
            timed_out  <= tmo_n;
            // The per-call counter keeps running from the request through GUARD into WAIT.
            if ((state_n != state) && !(state == S_ISSUE || state == S_GUARD))
                cnt <= '0;
            else
                cnt <= cnt + 32'd1;
            if (state == S_WAIT && state_n == S_CHECK) begin
                ret_q <= dut_return;
                to_q  <= dut_busy;
            end
            dut_reset <= (state_n == S_DRST);
            dut_req   <= (state_n == S_ISSUE);
            dut_idx   <= (state_n inside {S_ISSUE, S_GUARD, S_WAIT, S_CHECK}) ? IDX_WIDTH'(k_n) : '0;
            running   <= (state_n inside {S_DRST, S_SETTLE, S_ISSUE, S_GUARD, S_WAIT, S_CHECK});
            done      <= (state_n == S_DONE);
            pass      <= (state_n == S_DONE) && (err_n == '0);
        end
    end

endmodule

// File: tb/tb_sjr_method_checker.sv
// tb/tb_sjr_method_checker.sv - directed bench for sjr_method_checker
// Two instances: default geometry with TIMEOUT=50, and a 32-bit/8-call variant.
module tb_sjr_method_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // instance 0
    logic        start0 = 0, exp_we0 = 0;
    logic [1:0]  exp_addr0 = 0;
    logic        exp_data0 = 0;
    logic        c0_dut_reset, c0_dut_req, c0_running, c0_done, c0_pass, c0_timed_out;
    logic [31:0] c0_dut_idx;
    logic        c0_busy = 0;
    logic        c0_ret = 0;
    logic [2:0]  c0_err;
    logic [1:0]  c0_ff;

    // instance 1
    logic        start1 = 0, exp_we1 = 0;
    logic [2:0]  exp_addr1 = 0;
    logic [31:0] exp_data1 = 0;
    logic        c1_dut_reset, c1_dut_req, c1_running, c1_done, c1_pass, c1_timed_out;
    logic [31:0] c1_dut_idx;
    logic        c1_busy = 0;
    logic [31:0] c1_ret = 0;
    logic [3:0]  c1_err;
    logic [2:0]  c1_ff;

    sjr_method_checker #(.TIMEOUT(50)) u0 (
        .clk(clk), .reset(rst), .start(start0),
        .exp_we(exp_we0), .exp_addr(exp_addr0), .exp_data(exp_data0),
        .dut_reset(c0_dut_reset), .dut_req(c0_dut_req), .dut_idx(c0_dut_idx),
        .dut_busy(c0_busy), .dut_return(c0_ret),
        .running(c0_running), .done(c0_done), .pass(c0_pass),
        .err_count(c0_err), .first_fail(c0_ff), .timed_out(c0_timed_out)
    );

    sjr_method_checker #(.RET_WIDTH(32), .NUM_CALLS(8), .SETTLE_CYCLES(2), .TIMEOUT(100)) u1 (
        .clk(clk), .reset(rst), .start(start1),
        .exp_we(exp_we1), .exp_addr(exp_addr1), .exp_data(exp_data1),
        .dut_reset(c1_dut_reset), .dut_req(c1_dut_req), .dut_idx(c1_dut_idx),
        .dut_busy(c1_busy), .dut_return(c1_ret),
        .running(c1_running), .done(c1_done), .pass(c1_pass),
        .err_count(c1_err), .first_fail(c1_ff), .timed_out(c1_timed_out)
    );

    // Method models: busy for m_len cycles after a request; one index can hang forever.
    int          m0_len = 3;
    logic [31:0] m0_hang_idx = 32'hFFFF_FFFF;
    logic        m0_hang = 0;
    int          m0_cnt = 0;
    always @(posedge clk) begin
        if (c0_dut_reset) begin
            c0_busy <= 1'b0; m0_cnt <= 0; m0_hang <= 1'b0;
        end else if (c0_dut_req) begin
            c0_ret  <= 1'b1;
            c0_busy <= (m0_len > 0) || (c0_dut_idx == m0_hang_idx);
            m0_cnt  <= m0_len;
            m0_hang <= (c0_dut_idx == m0_hang_idx);
        end else if (!m0_hang && m0_cnt != 0) begin
            if (m0_cnt == 1) c0_busy <= 1'b0;
            m0_cnt <= m0_cnt - 1;
        end
    end

    int m1_cnt = 0;
    always @(posedge clk) begin
        if (c1_dut_reset) begin
            c1_busy <= 1'b0; m1_cnt <= 0;
        end else if (c1_dut_req) begin
            c1_ret  <= c1_dut_idx * 3;
            c1_busy <= 1'b1;
            m1_cnt  <= 2;
        end else if (m1_cnt != 0) begin
            if (m1_cnt == 1) c1_busy <= 1'b0;
            m1_cnt <= m1_cnt - 1;
        end
    end

    // Monitors, sampled mid-cycle.
    int          req_cyc[$];
    logic [31:0] req_idx[$];
    int          drst_n = 0, drst_first = 0;
    int          req1_n = 0, req1_first = 0;
    always @(negedge clk) begin
        if (c0_dut_req) begin req_cyc.push_back(cyc); req_idx.push_back(c0_dut_idx); end
        if (c0_dut_reset) begin if (drst_n == 0) drst_first = cyc; drst_n++; end
        if (c1_dut_req) begin if (req1_n == 0) req1_first = cyc; req1_n++; end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr0(input int a, input logic d);
        exp_we0 = 1; exp_addr0 = 2'(a); exp_data0 = d;
        @(negedge clk);
        exp_we0 = 0;
    endtask

    task automatic wr1(input int a, input logic [31:0] d);
        exp_we1 = 1; exp_addr1 = 3'(a); exp_data1 = d;
        @(negedge clk);
        exp_we1 = 0;
    endtask

    // Pulses start on instance 0 and returns the sampling cycle S; clears monitors.
    task automatic start_run0(output int s);
        req_cyc.delete(); req_idx.delete(); drst_n = 0;
        start0 = 1; s = cyc;
        @(negedge clk);
        start0 = 0;
    endtask

    task automatic wait_done(input int which, input int max);
        int n = 0;
        while (((which == 0) ? c0_done : c1_done) !== 1'b1 && n < max) begin
            @(negedge clk); n++;
        end
        chk("wait_done_bound", (n < max), 1);
    endtask

    initial begin
        int s;
        int n;
        @(negedge clk); @(negedge clk);
        chk("rst_dut_reset", c0_dut_reset, 0);
        chk("rst_dut_req",   c0_dut_req, 0);
        chk("rst_dut_idx",   c0_dut_idx, 0);
        chk("rst_status",    {c0_running, c0_done, c0_pass, c0_err, c0_ff, c0_timed_out}, 0);
        for (int i = 0; i < 4; i++) wr0(i, 1'b1);
        for (int i = 0; i < 8; i++) wr1(i, 32'(i * 3));
        rst = 0;
        @(negedge clk);

        // Basic run, with an ignored start during SETTLE.
        start_run0(s);
        repeat (50) @(negedge clk);
        start0 = 1; @(negedge clk); start0 = 0;
        wait_done(0, 1000);
        chk("t1_drst_first", drst_first, s + 1);
        chk("t1_drst_len",   drst_n, 6);
        chk("t1_req_count",  req_cyc.size(), 4);
        chk("t1_first_req",  req_cyc[0], s + 99);
        for (int i = 0; i < req_idx.size(); i++) chk("t1_req_idx", req_idx[i], i);
        chk("t1_period",     req_cyc[3] - req_cyc[0], 18);
        chk("t1_pass",       c0_pass, 1);
        chk("t1_err",        c0_err, 0);
        chk("t1_running",    c0_running, 0);

        // Mismatch on entry 2.
        wr0(2, 1'b0);
        start_run0(s);
        wait_done(0, 1000);
        chk("t2_pass",  c0_pass, 0);
        chk("t2_err",   c0_err, 1);
        chk("t2_ff",    c0_ff, 2);
        chk("t2_tmo",   c0_timed_out, 0);

        // Restart from DONE clears counters; call 1 hangs and times out.
        wr0(2, 1'b1);
        m0_hang_idx = 1;
        start_run0(s);
        chk("t3_done_drop", c0_done, 0);
        chk("t3_err_clr",   c0_err, 0);
        chk("t3_ff_clr",    c0_ff, 0);
        wait_done(0, 1000);
        chk("t3_tmo",       c0_timed_out, 1);
        chk("t3_err",       c0_err, 1);
        chk("t3_ff",        c0_ff, 1);
        chk("t3_pass",      c0_pass, 0);
        chk("t3_req_count", req_cyc.size(), 4);
        chk("t3_tmo_gap",   req_cyc[2] - req_cyc[1], 52);
        chk("t3_idx3",      req_idx[3], 3);

        // Early busy drop is not accepted before the guard expires.
        m0_hang_idx = 32'hFFFF_FFFF;
        m0_len = 1;
        start_run0(s);
        wait_done(0, 1000);
        chk("t4_gap01", req_cyc[1] - req_cyc[0], 6);
        chk("t4_gap23", req_cyc[3] - req_cyc[2], 6);
        chk("t4_pass",  c0_pass, 1);

        // Synchronous reset during WAIT of call 2.
        m0_len = 20;
        start_run0(s);
        n = 0;
        while (req_cyc.size() < 3 && n < 500) begin @(negedge clk); n++; end
        chk("t5_reach_call2", (n < 500), 1);
        repeat (6) @(negedge clk);
        chk("t5_running", c0_running, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("t5_rst_outs", {c0_dut_reset, c0_dut_req, c0_dut_idx, c0_running, c0_done,
                            c0_pass, c0_err, c0_ff, c0_timed_out}, 0);
        m0_len = 3;
        start_run0(s);
        wait_done(0, 1000);
        chk("t5_first_req", req_cyc[0], s + 99);
        chk("t5_pass",      c0_pass, 1);

        // Wide variant: 8 calls, return idx*3.
        start1 = 1; s = cyc; @(negedge clk); start1 = 0;
        wait_done(1, 1000);
        chk("t6_first_req", req1_first, s + 9);
        chk("t6_req_count", req1_n, 8);
        chk("t6_pass",      c1_pass, 1);
        chk("t6_err",       c1_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
